// File: rtl/load_sensor_pkg.sv
// Shared types for the drum load-sensing block.
//   state_t      : controller FSM states
//   load_class_t : load classification reported to the wash-programme controller
//   fault_code_t : reason for a failed measurement
//   classify()   : maps a window average onto a load class
package load_sensor_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SAMPLE,
    ST_EVAL,
    ST_REDIST,
    ST_DONE,
    ST_FAULT
  } state_t;

  typedef enum logic [1:0] {
    LC_EMPTY  = 2'd0,
    LC_LIGHT  = 2'd1,
    LC_MEDIUM = 2'd2,
    LC_HEAVY  = 2'd3
  } load_class_t;

  typedef enum logic [1:0] {
    FC_NONE      = 2'd0,
    FC_OVERLOAD  = 2'd1,
    FC_IMBALANCE = 2'd2
  } fault_code_t;

  // Each threshold is the inclusive lower bound of its class.
  function automatic load_class_t classify(input int unsigned avg,
                                           input int unsigned thr_low,
                                           input int unsigned thr_med,
                                           input int unsigned thr_high);
    if (avg >= thr_high)     return LC_HEAVY;
    else if (avg >= thr_med) return LC_MEDIUM;
    else if (avg >= thr_low) return LC_LIGHT;
    else                     return LC_EMPTY;
  endfunction

endpackage

// File: rtl/load_sensor_ctrl_if.sv
// Weight-sample stream from the load-cell front end (valid/ready).
//   sample_valid : front end presents a sample
//   sample_data  : weight sample
//   sample_ready : consumer accepts a sample this cycle
interface load_sensor_ctrl_if #(
  parameter int unsigned W_WIDTH = 8
);
  logic               sample_valid;
  logic [W_WIDTH-1:0] sample_data;
  logic               sample_ready;

  modport master (output sample_valid, output sample_data, input sample_ready);
  modport slave  (input sample_valid, input sample_data, output sample_ready);
endinterface

// File: rtl/load_stats.sv
// Window statistics: running sum, min, max and sample count.
//   clk, reset_n  : clock, async active-low reset
//   clear         : restart the window (priority over strobe)
//   strobe, data  : accepted sample
//   window_full_c : this strobe completes the window of 2**LOG2_N samples
//   avg_c         : truncated window average
//   spread_c      : max - min over the window
module load_stats #(
  parameter int unsigned W_WIDTH = 8,
  parameter int unsigned LOG2_N  = 3
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               clear,
  input  logic               strobe,
  input  logic [W_WIDTH-1:0] data,
  output logic               window_full_c,
  output logic [W_WIDTH-1:0] avg_c,
  output logic [W_WIDTH-1:0] spread_c
);

  localparam int unsigned SUM_W = W_WIDTH + LOG2_N;
  localparam int unsigned CNT_W = LOG2_N + 1;
  localparam int unsigned N     = 1 << LOG2_N;

  logic [SUM_W-1:0]   sum;
  logic [W_WIDTH-1:0] min_q;
  logic [W_WIDTH-1:0] max_q;
  logic [CNT_W-1:0]   cnt;

  // Accumulate; sum is wide enough that a full window cannot overflow.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sum   <= '0;
      min_q <= '1;
      max_q <= '0;
      cnt   <= '0;
    end else if (clear) begin
      sum   <= '0;
      min_q <= '1;
      max_q <= '0;
      cnt   <= '0;
    end else if (strobe) begin
      sum   <= sum + SUM_W'(data);
      min_q <= (data < min_q) ? data : min_q;
      max_q <= (data > max_q) ? data : max_q;
      cnt   <= cnt + CNT_W'(1);
    end
  end

  assign window_full_c = strobe && (cnt == CNT_W'(N - 1));
  assign avg_c         = W_WIDTH'(sum >> LOG2_N);
  assign spread_c      = max_q - min_q;

endmodule

// File: rtl/load_sensor_ctrl.sv
// Drum load-sensing controller: averages a window of weight samples, retries
// drum redistribution on imbalance, classifies the load or reports a fault.
//   clk, reset_n : clock, async active-low reset
//   start        : level request, held for measurement and acknowledge
//   abort        : synchronous cancel
//   smp          : sample stream (slave side)
//   busy, redistribute, load_ready, load_class, avg_weight, imbalance,
//   retry_cnt, fault, fault_code : registered status / result outputs
module load_sensor_ctrl
  import load_sensor_pkg::*;
#(
  parameter int unsigned W_WIDTH       = 8,
  parameter int unsigned LOG2_N        = 3,
  parameter int unsigned THR_LOW       = 16,
  parameter int unsigned THR_MED       = 64,
  parameter int unsigned THR_HIGH      = 128,
  parameter int unsigned THR_MAX       = 200,
  parameter int unsigned SPREAD_MAX    = 24,
  parameter int unsigned MAX_RETRIES   = 3,
  parameter int unsigned SETTLE_CYCLES = 16
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic                                 start,
  input  logic                                 abort,
  load_sensor_ctrl_if.slave                    smp,
  output logic                                 busy,
  output logic                                 redistribute,
  output logic                                 load_ready,
  output logic [1:0]                           load_class,
  output logic [W_WIDTH-1:0]                   avg_weight,
  output logic                                 imbalance,
  output logic [$clog2(MAX_RETRIES+1)-1:0]     retry_cnt,
  output logic                                 fault,
  output logic [1:0]                           fault_code
);

  localparam int unsigned RC_W  = $clog2(MAX_RETRIES + 1);
  localparam int unsigned TMR_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [W_WIDTH-1:0] THR_MAX_W    = W_WIDTH'(THR_MAX);
  localparam logic [W_WIDTH-1:0] SPREAD_MAX_W = W_WIDTH'(SPREAD_MAX);

  state_t             state, state_d;
  logic [TMR_W-1:0]   tmr, tmr_d;
  logic               sample_ready_q;
  logic               accept_c, clear_c, window_full_c, over_c, imb_c, cancel_c;
  logic [W_WIDTH-1:0] avg_c, spread_c;

  logic               busy_d, redistribute_d, load_ready_d, sample_ready_d;
  logic               imbalance_d, fault_d;
  logic [1:0]         load_class_d, fault_code_d;
  logic [W_WIDTH-1:0] avg_weight_d;
  logic [RC_W-1:0]    retry_d;

  assign smp.sample_ready = sample_ready_q;
  assign accept_c = smp.sample_valid && sample_ready_q;
  // Window restarts while idle and throughout the settle period.
  assign clear_c  = (state == ST_IDLE) || (state == ST_REDIST);
  assign over_c   = avg_c > THR_MAX_W;
  assign imb_c    = spread_c > SPREAD_MAX_W;

  load_stats #(
    .W_WIDTH(W_WIDTH),
    .LOG2_N (LOG2_N)
  ) u_stats (
    .clk          (clk),
    .reset_n      (reset_n),
    .clear        (clear_c),
    .strobe       (accept_c),
    .data         (smp.sample_data),
    .window_full_c(window_full_c),
    .avg_c        (avg_c),
    .spread_c     (spread_c)
  );

  // Next state and next registered outputs.
  always_comb begin
    state_d      = state;
    tmr_d        = '0;
    load_class_d = load_class;
    avg_weight_d = avg_weight;
    imbalance_d  = imbalance;
    retry_d      = retry_cnt;
    fault_code_d = fault_code;
    cancel_c     = abort ||
                   (!start && (state inside {ST_SAMPLE, ST_EVAL, ST_REDIST}));

    unique case (state)
      ST_IDLE:   if (start) state_d = ST_SAMPLE;
      ST_SAMPLE: if (window_full_c) state_d = ST_EVAL;
      ST_EVAL: begin
        imbalance_d  = imb_c;
        avg_weight_d = avg_c;
        // Overload wins over imbalance and is never retried.
        if (over_c) begin
          state_d      = ST_FAULT;
          fault_code_d = FC_OVERLOAD;
        end else if (imb_c && (retry_cnt < RC_W'(MAX_RETRIES))) begin
          state_d = ST_REDIST;
          retry_d = retry_cnt + RC_W'(1);
        end else if (imb_c) begin
          state_d      = ST_FAULT;
          fault_code_d = FC_IMBALANCE;
        end else begin
          state_d      = ST_DONE;
          load_class_d = classify(32'(avg_c), THR_LOW, THR_MED, THR_HIGH);
        end
      end
      ST_REDIST: begin
        tmr_d = tmr + TMR_W'(1);
        if (tmr == TMR_W'(SETTLE_CYCLES - 1)) state_d = ST_SAMPLE;
      end
      ST_DONE, ST_FAULT: if (!start) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    if (cancel_c) state_d = ST_IDLE;

    // Returning to idle drops every result so nothing stale is reported.
    if (state_d == ST_IDLE) begin
      load_class_d = '0;
      avg_weight_d = '0;
      imbalance_d  = 1'b0;
      retry_d      = '0;
      fault_code_d = FC_NONE;
    end

    busy_d         = state_d inside {ST_SAMPLE, ST_EVAL, ST_REDIST};
    sample_ready_d = (state_d == ST_SAMPLE);
    redistribute_d = (state_d == ST_REDIST);
    load_ready_d   = (state_d == ST_DONE);
    fault_d        = (state_d == ST_FAULT);
  end

  // State, settle timer and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= ST_IDLE;
      tmr            <= '0;
      sample_ready_q <= 1'b0;
      busy           <= 1'b0;
      redistribute   <= 1'b0;
      load_ready     <= 1'b0;
      load_class     <= '0;
      avg_weight     <= '0;
      imbalance      <= 1'b0;
      retry_cnt      <= '0;
      fault          <= 1'b0;
      fault_code     <= '0;
    end else begin
      state          <= state_d;
      tmr            <= tmr_d;
      sample_ready_q <= sample_ready_d;
      busy           <= busy_d;
      redistribute   <= redistribute_d;
      load_ready     <= load_ready_d;
      load_class     <= load_class_d;
      avg_weight     <= avg_weight_d;
      imbalance      <= imbalance_d;
      retry_cnt      <= retry_d;
      fault          <= fault_d;
      fault_code     <= fault_code_d;
    end
  end

endmodule

// File: tb/tb_load_sensor_ctrl.sv
// Self-checking bench for load_sensor_ctrl: directed threshold/imbalance/abort
// cases plus randomized windows and back-pressure, against a window-level model.
module tb_load_sensor_ctrl;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       busy, redistribute, load_ready, imbalance, fault;
  logic [1:0] load_class, fault_code, retry_cnt;
  logic [7:0] avg_weight;

  int checks = 0;
  int errors = 0;
  int exp_retry;
  logic [7:0] win [8];

  load_sensor_ctrl_if #(.W_WIDTH(8)) smp ();

  load_sensor_ctrl #(
    .W_WIDTH(8), .LOG2_N(3), .THR_LOW(16), .THR_MED(64), .THR_HIGH(128),
    .THR_MAX(200), .SPREAD_MAX(24), .MAX_RETRIES(3), .SETTLE_CYCLES(16)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .abort       (abort),
    .smp         (smp.slave),
    .busy        (busy),
    .redistribute(redistribute),
    .load_ready  (load_ready),
    .load_class  (load_class),
    .avg_weight  (avg_weight),
    .imbalance   (imbalance),
    .retry_cnt   (retry_cnt),
    .fault       (fault),
    .fault_code  (fault_code)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({busy, redistribute, load_ready, load_class, avg_weight, imbalance,
                retry_cnt, fault, fault_code, smp.sample_ready});
  endfunction

  function automatic int expect_class(input int avg);
    if (avg >= 128) return 3;
    if (avg >= 64)  return 2;
    if (avg >= 16)  return 1;
    return 0;
  endfunction

  // Offer win[0..n-1] with valid asserted with probability prob percent.
  task automatic feed_n(input int n, input int prob);
    int idx = 0;
    int guard = 0;
    bit v, hs;
    while (idx < n && guard < 400) begin
      v = ($urandom_range(99) < 32'(prob));
      smp.sample_valid = v;
      smp.sample_data  = v ? win[idx] : 8'($urandom);
      hs = v && smp.sample_ready;
      tick;
      if (hs) idx++;
      guard++;
    end
    smp.sample_valid = 1'b0;
    if (idx < n) check("feed_timeout", 32'(idx), 32'(n));
  endtask

  // mode 0: all a; 1: alternate a/b; 2: random in [a,b].
  // outcome: 0 done, 1 redistribution, 2 fault.
  task automatic do_window(input int mode, input int a, input int b, input int prob,
                           output int outcome);
    int sum, mn, mx, avg, spr, n;
    sum = 0; mn = 255; mx = 0;
    for (int i = 0; i < 8; i++) begin
      case (mode)
        0:       win[i] = 8'(a);
        1:       win[i] = (i % 2 == 1) ? 8'(b) : 8'(a);
        default: win[i] = 8'($urandom_range(b, a));
      endcase
      sum += int'(win[i]);
      if (int'(win[i]) < mn) mn = int'(win[i]);
      if (int'(win[i]) > mx) mx = int'(win[i]);
    end
    feed_n(8, prob);
    avg = sum / 8;
    spr = mx - mn;
    check("eval_load_ready", 32'(load_ready), 0);
    check("eval_sample_ready", 32'(smp.sample_ready), 0);
    check("eval_busy", 32'(busy), 1);
    tick;
    if (avg > 200) begin
      outcome = 2;
      check("ovl_fault", 32'(fault), 1);
      check("ovl_code", 32'(fault_code), 1);
      check("ovl_avg", 32'(avg_weight), 32'(avg));
      check("ovl_retry", 32'(retry_cnt), 32'(exp_retry));
      check("ovl_ready", 32'(load_ready), 0);
    end else if (spr > 24 && exp_retry < 3) begin
      outcome = 1;
      exp_retry++;
      check("redist_retry", 32'(retry_cnt), 32'(exp_retry));
      check("redist_srdy", 32'(smp.sample_ready), 0);
      n = 0;
      while (redistribute === 1'b1 && n < 64) begin
        n++;
        tick;
      end
      check("redist_len", 32'(n), 16);
      check("redist_resample", 32'(smp.sample_ready), 1);
    end else if (spr > 24) begin
      outcome = 2;
      check("imb_fault", 32'(fault), 1);
      check("imb_code", 32'(fault_code), 2);
      check("imb_flag", 32'(imbalance), 1);
      check("imb_retry", 32'(retry_cnt), 3);
      check("imb_avg", 32'(avg_weight), 32'(avg));
    end else begin
      outcome = 0;
      check("done_ready", 32'(load_ready), 1);
      check("done_class", 32'(load_class), 32'(expect_class(avg)));
      check("done_avg", 32'(avg_weight), 32'(avg));
      check("done_retry", 32'(retry_cnt), 32'(exp_retry));
      check("done_fault", 32'(fault), 0);
      check("done_imb", 32'(imbalance), 0);
      check("done_busy", 32'(busy), 0);
    end
  endtask

  task automatic finish_job;
    start = 1'b0;
    tick;
    check("idle_outs", all_outs(), 0);
  endtask

  task automatic run_job(input int m1, input int a1, input int b1,
                         input int m2, input int a2, input int b2, input int prob);
    int oc;
    exp_retry = 0;
    start = 1'b1;
    do_window(m1, a1, b1, prob, oc);
    for (int k = 0; k < 4 && oc == 1; k++) do_window(m2, a2, b2, prob, oc);
    tick;
    check("hold_result", 32'({load_ready, fault}), (oc == 0) ? 32'd2 : 32'd1);
    finish_job();
  endtask

  initial begin
    int lo, hi, oc;
    smp.sample_valid = 1'b0;
    smp.sample_data  = '0;
    #3;
    check("reset_outs", all_outs(), 0);
    #9 reset_n = 1'b1;
    tick;

    // Balanced load and threshold edges
    run_job(0, 100, 0, 0, 0, 0, 100);
    run_job(0, 64, 0, 0, 0, 0, 100);
    run_job(0, 63, 0, 0, 0, 0, 100);
    run_job(0, 15, 0, 0, 0, 0, 100);
    run_job(0, 16, 0, 0, 0, 0, 100);
    run_job(0, 128, 0, 0, 0, 0, 100);
    run_job(0, 200, 0, 0, 0, 0, 100);
    run_job(0, 201, 0, 0, 0, 0, 100);

    // Imbalance recovery and exhaustion
    run_job(1, 80, 120, 0, 100, 0, 100);
    run_job(1, 80, 120, 1, 80, 120, 100);

    // Randomized windows with back-pressure
    for (int j = 0; j < 16; j++) begin
      lo = int'($urandom_range(255));
      hi = lo + int'($urandom_range(40));
      if (hi > 255) hi = 255;
      run_job(2, lo, hi, 2, lo, hi, int'($urandom_range(100, 30)));
    end

    // Abort on the cycle of the 8th handshake
    start = 1'b1;
    for (int i = 0; i < 8; i++) win[i] = 8'd50;
    feed_n(7, 100);
    check("abort_pre_ready", 32'(smp.sample_ready), 1);
    smp.sample_valid = 1'b1;
    smp.sample_data  = 8'd50;
    abort = 1'b1;
    tick;
    abort = 1'b0;
    smp.sample_valid = 1'b0;
    check("abort_idle", all_outs(), 0);
    tick;
    check("abort_restart", 32'({busy, smp.sample_ready, load_ready}), 32'b110);
    tick;
    check("abort_no_stale", 32'(load_ready), 0);
    finish_job();

    // start dropped during redistribution
    start = 1'b1;
    for (int i = 0; i < 8; i++) win[i] = (i % 2 == 1) ? 8'd120 : 8'd80;
    feed_n(8, 100);
    tick;
    check("redist_active", 32'({redistribute, retry_cnt}), 32'b101);
    tick; tick; tick;
    start = 1'b0;
    tick;
    check("redist_cancel", all_outs(), 0);

    // Asynchronous reset in SAMPLE
    start = 1'b1;
    for (int i = 0; i < 8; i++) win[i] = 8'd100;
    feed_n(3, 100);
    #2 reset_n = 1'b0;
    #1;
    check("arst_sample", all_outs(), 0);
    start = 1'b0;
    reset_n = 1'b1;
    tick;
    run_job(0, 90, 0, 0, 0, 0, 100);

    // Asynchronous reset in DONE
    exp_retry = 0;
    start = 1'b1;
    do_window(0, 150, 0, 100, oc);
    #2 reset_n = 1'b0;
    #1;
    check("arst_done", all_outs(), 0);
    start = 1'b0;
    reset_n = 1'b1;
    tick;
    run_job(0, 40, 0, 0, 0, 0, 70);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
